// File: rtl/binary_run_encoder.sv
// Run-length encoder for binarized pixel lines: emits (colour, length, last) tokens
// through a show-ahead FIFO. Tokens that do not fit are dropped and flagged.
module binary_run_encoder #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned LEN_W      = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      pixel_binary,
  input  logic             pixel_valid,
  input  logic             line_end,
  output logic             run_valid,
  input  logic             run_ready,
  output logic             run_color,
  output logic [LEN_W-1:0] run_length,
  output logic             run_last,
  output logic             overflow
);

  localparam int unsigned UnusedImgWidth = IMG_WIDTH;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TokW = LEN_W + 2;

  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
  localparam logic [LEN_W-1:0] LenMax = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic              cur_color_q, cur_color_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic              overflow_q, overflow_d;

  logic [TokW-1:0]   mem_q [FIFO_DEPTH];
  logic [TokW-1:0]   mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              pix_color;
  logic              unused_pixel_bits;
  logic              push0, push1;
  logic [TokW-1:0]   tok0, tok1;
  logic              pop, acc0, acc1;
  logic [CntW:0]     space;
  logic [TokW-1:0]   head;

  assign pix_color         = pixel_binary[11];
  assign unused_pixel_bits = ^pixel_binary[10:0];

  // Run tracker: decides which tokens close on this pixel, independent of FIFO space.
  always_comb begin
    state_d     = state_q;
    cur_color_d = cur_color_q;
    cur_len_d   = cur_len_q;
    push0       = 1'b0;
    push1       = 1'b0;
    tok0        = '0;
    tok1        = '0;
    if (pixel_valid) begin
      unique case (state_q)
        StIdle: begin
          if (line_end) begin
            push0 = 1'b1;
            tok0  = {pix_color, LenOne, 1'b1};
          end else begin
            state_d     = StRun;
            cur_color_d = pix_color;
            cur_len_d   = LenOne;
          end
        end
        StRun: begin
          if ((pix_color != cur_color_q) || (cur_len_q == LenMax)) begin
            push0 = 1'b1;
            tok0  = {cur_color_q, cur_len_q, 1'b0};
            if (line_end) begin
              push1   = 1'b1;
              tok1    = {pix_color, LenOne, 1'b1};
              state_d = StIdle;
            end else begin
              cur_color_d = pix_color;
              cur_len_d   = LenOne;
            end
          end else if (line_end) begin
            push0   = 1'b1;
            tok0    = {pix_color, cur_len_q + LenOne, 1'b1};
            state_d = StIdle;
          end else begin
            cur_len_d = cur_len_q + LenOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A same-cycle pop frees one slot for the incoming pushes.
  always_comb begin
    pop   = run_valid & run_ready;
    space = (CntW + 1)'(FIFO_DEPTH) - {1'b0, count_q} + {{CntW{1'b0}}, pop};
    acc0  = push0 & (space != '0);
    acc1  = push1 & (space >= (CntW + 1)'(2));

    mem_d = mem_q;
    if (acc0) mem_d[wr_ptr_q] = tok0;
    if (acc1) mem_d[wr_ptr_q + PtrW'(1)] = tok1;

    wr_ptr_d   = wr_ptr_q + PtrW'(acc0) + PtrW'(acc1);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    count_d    = count_q + CntW'(acc0) + CntW'(acc1) - CntW'(pop);
    overflow_d = overflow_q | (push0 & ~acc0) | (push1 & ~acc1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_color_q <= 1'b0;
      cur_len_q   <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_color_q <= cur_color_d;
      cur_len_q   <= cur_len_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    run_valid  = (count_q != '0);
    run_color  = run_valid ? head[TokW-1]  : 1'b0;
    run_length = run_valid ? head[LEN_W:1] : '0;
    run_last   = run_valid ? head[0]       : 1'b0;
    overflow   = overflow_q;
  end

endmodule
